// File: rtl/cube.sv
// cube: iterative unsigned cube unit, y = x^3 for an 8-bit operand, 24-bit result.
// A shift-add multiplier produces one partial product per clock over two passes:
// SQ computes x*x, then CU computes (x*x)*x. Handshake is start/busy, matching
// the cubic-root unit so the two can be chained or cross-checked.
//
// Configuration macro: CUBE_EARLY_EXIT_EN
//   undefined (default): every pass is exactly 8 steps, latency is 16 cycles.
//   defined            : a pass ends on the step after which the shifted
//                        multiplier is zero (at least one step per pass), so
//                        latency is 2*(msb_index(x)+1) cycles. Results are
//                        identical in both builds.
module cube (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x_bi,
    input  logic        start,
    output logic        busy_o,
    output logic [23:0] y_bo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_CU   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  x_q,     x_d;
    logic [23:0] a_q,     a_d;
    logic [7:0]  b_q,     b_d;
    logic [23:0] acc_q,   acc_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [23:0] y_q,     y_d;

    // Shared step arithmetic; the FSM decides where the results go.
    logic [23:0] acc_next_s;
    logic [23:0] a_shift_s;
    logic [7:0]  b_shift_s;
    logic [2:0]  cnt_inc_s;
    logic        pass_done_s;

    // One shift-add step: conditional add of the multiplicand, then shift both operands.
    always_comb begin
        acc_next_s = acc_q + (b_q[0] ? a_q : 24'd0);
        a_shift_s  = {a_q[22:0], 1'b0};
        b_shift_s  = {1'b0, b_q[7:1]};
        cnt_inc_s  = cnt_q + 3'd1;
    end

    // Pass termination: fixed 8 steps, or stop once no multiplier bits remain.
    always_comb begin
`ifdef CUBE_EARLY_EXIT_EN
        pass_done_s = (b_shift_s == 8'd0);
`else
        pass_done_s = (cnt_q == 3'd7);
`endif
    end

    // Next-state and datapath control; every register holds unless a state moves it.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Operand is captured only on the accepting edge.
                    x_d     = x_bi;
                    a_d     = {16'd0, x_bi};
                    b_d     = x_bi;
                    acc_d   = 24'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_SQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SQ: begin
                if (pass_done_s) begin
                    // x^2 fits in 16 bits; it becomes the multiplicand of the cube pass.
                    a_d     = acc_next_s;
                    b_d     = x_q;
                    acc_d   = 24'd0;
                    cnt_d   = 3'd0;
                    state_d = ST_CU;
                end else begin
                    a_d     = a_shift_s;
                    b_d     = b_shift_s;
                    acc_d   = acc_next_s;
                    cnt_d   = cnt_inc_s;
                    state_d = ST_SQ;
                end
            end
            ST_CU: begin
                if (pass_done_s) begin
                    // Result register only changes here, so it holds across later runs.
                    y_d     = acc_next_s;
                    a_d     = a_shift_s;
                    b_d     = b_shift_s;
                    acc_d   = acc_next_s;
                    cnt_d   = cnt_inc_s;
                    state_d = ST_IDLE;
                end else begin
                    a_d     = a_shift_s;
                    b_d     = b_shift_s;
                    acc_d   = acc_next_s;
                    cnt_d   = cnt_inc_s;
                    state_d = ST_CU;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run and clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= 8'd0;
            a_q     <= 24'd0;
            b_q     <= 8'd0;
            acc_q   <= 24'd0;
            cnt_q   <= 3'd0;
            y_q     <= 24'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign y_bo   = y_q;

endmodule

// File: tb/tb_cube.sv
// tb_cube: directed-vector scoreboard bench for cube. Stimulus pushes expected
// result and latency into a queue; a negedge monitor pops on busy falling and
// compares, and also checks that y_bo holds its previous value while busy.
`timescale 1ns/1ps
module tb_cube;

    logic        clk;
    logic        reset;
    logic [7:0]  x_bi;
    logic        start;
    logic        busy_o;
    logic [23:0] y_bo;

    typedef struct {
        logic [7:0]  x;
        logic [23:0] y;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor state
    logic        prev_busy = 1'b0;
    int          busy_cycles = 0;
    logic [23:0] last_y = 24'd0;

    cube dut (
        .clk    (clk),
        .reset  (reset),
        .x_bi   (x_bi),
        .start  (start),
        .busy_o (busy_o),
        .y_bo   (y_bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [7:0] x);
        int m;
        m = 0;
`ifdef CUBE_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) if (x[i]) m = i;
        return 2 * (m + 1);
`else
        return 16 + (m * 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one start pulse; optionally register the expected completion.
    task automatic launch(input logic [7:0] x, input logic [23:0] y, input bit push);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.x = x; e.y = y; e.lat = exp_lat(x);
            sb_q.push_back(e);
        end
        x_bi  = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_bi  = 8'hAA;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: busy_o still 1, expected 0 within 40 cycles", name);
        end
    endtask

    // Monitor: count busy cycles, check hold value, score each completion.
    always @(negedge clk) begin
        if (reset) begin
            prev_busy   = 1'b0;
            busy_cycles = 0;
            last_y      = 24'd0;
        end else begin
            if (busy_o) begin
                busy_cycles++;
                check("y_hold", {8'd0, y_bo}, {8'd0, last_y});
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_completion: y_bo=0x%0h, expected no completion", y_bo);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("y_x%0d", e.x), {8'd0, y_bo}, {8'd0, e.y});
                    check($sformatf("lat_x%0d", e.x), busy_cycles, e.lat);
                    last_y = e.y;
                end
                busy_cycles = 0;
            end
            prev_busy = busy_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_bi  = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_y", {8'd0, y_bo}, 32'd0);

        // Basic vector, then x=0 after prior 27 (monitor checks hold while busy).
        launch(8'd3,   24'd27,      1'b1); wait_idle("x3");
        launch(8'd0,   24'd0,       1'b1); wait_idle("x0");
        launch(8'd255, 24'hFD02FF,  1'b1); wait_idle("x255");
        launch(8'd1,   24'd1,       1'b1); wait_idle("x1");
        launch(8'd7,   24'd343,     1'b1); wait_idle("x7");
        launch(8'd128, 24'h200000,  1'b1); wait_idle("x128");
        launch(8'd10,  24'd1000,    1'b1); wait_idle("x10");
        launch(8'd5,   24'd125,     1'b1); wait_idle("x5");

        // Start during busy is ignored.
        launch(8'd4, 24'd64, 1'b1);
        repeat (3) @(negedge clk);
        x_bi  = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("x4_ignore");
        repeat (2) @(negedge clk);
        check("ignored_start_idle", {31'd0, busy_o}, 32'd0);

        // Reset during a run aborts immediately and drops the result.
        launch(8'd200, 24'd0, 1'b0);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_y", {8'd0, y_bo}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_abort_busy", {31'd0, busy_o}, 32'd0);
        launch(8'd2, 24'd8, 1'b1); wait_idle("x2");

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d completions outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
